// File: rtl/scg_scheduler.sv
// scg_scheduler: picks one of six SDRAM command-sequence generators
// (init, srx, ref, sre, rd, wr), runs its start/done handshake and muxes
// its command onto the SDRAM bus. Initialised and self-refresh modes are
// tracked so that only legal sequences are granted.
// Ports: clk, rst (sync, active-high); req/done/start/ack [5:0] indexed
// 0 init, 1 srx, 2 ref, 3 sre, 4 rd, 5 wr; cmd_in[4i+3:4i] per generator;
// cmd_out SDRAM command; busy, init_done, self_ref, timeout_err status.
module scg_scheduler #(
    parameter logic [3:0] NOP_CMD     = 4'b0111,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  req,
    output logic [5:0]  ack,
    output logic [5:0]  start,
    input  logic [5:0]  done,
    input  logic [23:0] cmd_in,
    output logic [3:0]  cmd_out,
    output logic        busy,
    output logic        init_done,
    output logic        self_ref,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_REL   = 2'd2;

    // The count is checked before its increment lands, so comparing
    // against LIMIT aborts on the cycle the count would reach TIMEOUT_CYC.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       init_q, init_d;
    logic       sr_q, sr_d;
    logic       to_q, to_d;
    logic       last_wr_q, last_wr_d;

    logic [5:0] elig;
    logic [2:0] win;
    logic       win_vld;
    logic       done_g;
    logic       limit;
    logic [5:0] ack_c;

    always_comb begin
        // Mode gating: before init only init may run; in self-refresh
        // only the exit sequence; otherwise init/srx are meaningless.
        elig = 6'b0;
        if (!init_q) begin
            elig[0] = req[0];
        end else if (sr_q) begin
            elig[1] = req[1];
        end else begin
            elig[5:2] = req[5:2];
        end

        win_vld = |elig;
        win     = 3'd0;
        if (elig[0]) begin
            win = 3'd0;
        end else if (elig[1]) begin
            win = 3'd1;
        end else if (elig[2]) begin
            win = 3'd2;
        end else if (elig[3]) begin
            win = 3'd3;
        end else if (elig[4] && elig[5]) begin
            win = last_wr_q ? 3'd4 : 3'd5;
        end else if (elig[4]) begin
            win = 3'd4;
        end else if (elig[5]) begin
            win = 3'd5;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        init_d    = init_q;
        sr_d      = sr_q;
        to_d      = to_q;
        last_wr_d = last_wr_q;
        ack_c     = 6'b0;
        done_g    = done[gnt_q];
        limit     = (cnt_q >= LIMIT);

        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_START;
                    gnt_d   = win;
                    cnt_d   = 8'd0;
                end
            end
            S_START: begin
                cnt_d = cnt_q + 8'd1;
                // done beats the timeout when both land together
                if (done_g) begin
                    state_d = S_REL;
                end else if (limit) begin
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end
            end
            S_REL: begin
                cnt_d = cnt_q + 8'd1;
                if (!done_g) begin
                    state_d       = S_IDLE;
                    ack_c[gnt_q]  = 1'b1;
                end else if (limit) begin
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ack_c[0]) init_d    = 1'b1;
        if (ack_c[3]) sr_d      = 1'b1;
        if (ack_c[1]) sr_d      = 1'b0;
        if (ack_c[4]) last_wr_d = 1'b0;
        if (ack_c[5]) last_wr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= 3'd0;
            cnt_q     <= 8'd0;
            init_q    <= 1'b0;
            sr_q      <= 1'b0;
            to_q      <= 1'b0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            init_q    <= init_d;
            sr_q      <= sr_d;
            to_q      <= to_d;
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        start = 6'b0;
        if (state_q == S_START) begin
            start[gnt_q] = 1'b1;
        end
        busy    = (state_q != S_IDLE);
        cmd_out = busy ? cmd_in[{gnt_q, 2'b00} +: 4] : NOP_CMD;
    end

    assign ack         = ack_c;
    assign init_done   = init_q;
    assign self_ref    = sr_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_scg_scheduler.sv
// tb_scg_scheduler: randomized scenario bench for scg_scheduler against a
// transaction-level reference of grant order, handshake timing and modes.
module tb_scg_scheduler;

    localparam logic [3:0] NOP = 4'b0111;
    localparam int         TO  = 8;

    logic        clk;
    logic        rst;
    logic [5:0]  req;
    logic [5:0]  ack;
    logic [5:0]  start;
    logic [5:0]  done;
    logic [23:0] cmd_in;
    logic [3:0]  cmd_out;
    logic        busy;
    logic        init_done;
    logic        self_ref;
    logic        timeout_err;

    int vecs;
    int errs;

    bit m_init;
    bit m_sr;
    bit m_lastwr;
    bit m_to;

    scg_scheduler #(
        .NOP_CMD     (NOP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .start       (start),
        .done        (done),
        .cmd_in      (cmd_in),
        .cmd_out     (cmd_out),
        .busy        (busy),
        .init_done   (init_done),
        .self_ref    (self_ref),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [5:0] r);
        if (!m_init) return r[0] ? 0 : -1;
        if (m_sr) return r[1] ? 1 : -1;
        if (r[2]) return 2;
        if (r[3]) return 3;
        if (r[4] && r[5]) return m_lastwr ? 4 : 5;
        if (r[4]) return 4;
        if (r[5]) return 5;
        return -1;
    endfunction

    task automatic model_reset();
        m_init   = 1'b0;
        m_sr     = 1'b0;
        m_lastwr = 1'b1;
        m_to     = 1'b0;
    endtask

    // Cycle 0 is an IDLE cycle where r is applied; the granted generator
    // raises done at cycle dh and drops it dl cycles after start falls.
    task automatic run_grant(input logic [5:0] r, input int dh,
                             input int dl, input logic [23:0] cw);
        int g;
        logic [5:0] oh;
        logic [5:0] es;
        logic [5:0] ea;
        logic [3:0] ec;
        g = pick(r);
        if (g < 0) return;
        oh = 6'b1 << g;
        cmd_in = cw;
        ec = cw[4*g +: 4];
        @(negedge clk);
        req  = r;
        done = 6'($urandom);
        #1;
        vecs++;
        if (busy !== 1'b0 || start !== 6'b0 || cmd_out !== NOP) begin
            errs++;
            $display("FAIL idle_c0: busy=%b start=%b cmd=%h want 0/0/%h",
                     busy, start, cmd_out, NOP);
        end
        vecs++;
        if ({init_done, self_ref, timeout_err} !== {m_init, m_sr, m_to}) begin
            errs++;
            $display("FAIL modes: got %b want %b",
                     {init_done, self_ref, timeout_err}, {m_init, m_sr, m_to});
        end
        for (int c = 1; c <= dh + dl + 1; c++) begin
            @(negedge clk);
            req  = (r & oh) | (6'($urandom) & ~oh);
            done = 6'($urandom) & ~oh;
            if (c >= dh && c <= dh + dl) done[g] = 1'b1;
            #1;
            es = (c <= dh) ? oh : 6'b0;
            ea = (c == dh + dl + 1) ? oh : 6'b0;
            vecs++;
            if (start !== es) begin
                errs++;
                $display("FAIL start g%0d c%0d: got %b want %b",
                         g, c, start, es);
            end
            vecs++;
            if (ack !== ea) begin
                errs++;
                $display("FAIL ack g%0d c%0d: got %b want %b", g, c, ack, ea);
            end
            vecs++;
            if (busy !== 1'b1 || cmd_out !== ec) begin
                errs++;
                $display("FAIL busy_cmd g%0d c%0d: got %b/%h want 1/%h",
                         g, c, busy, cmd_out, ec);
            end
        end
        req  = r & ~oh;
        done = 6'b0;
        unique case (g)
            0: m_init   = 1'b1;
            1: m_sr     = 1'b0;
            3: m_sr     = 1'b1;
            4: m_lastwr = 1'b0;
            5: m_lastwr = 1'b1;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = 6'b0;
        done = 6'b0;
        @(negedge clk);
        #1;
        vecs++;
        if (start !== 6'b0 || ack !== 6'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_hs: start=%b ack=%b busy=%b want 0",
                     start, ack, busy);
        end
        vecs++;
        if (cmd_out !== NOP) begin
            errs++;
            $display("FAIL reset_cmd: got %h want %h", cmd_out, NOP);
        end
        vecs++;
        if ({init_done, self_ref, timeout_err} !== 3'b000) begin
            errs++;
            $display("FAIL reset_modes: got %b want 000",
                     {init_done, self_ref, timeout_err});
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_init_gating();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req  = 6'b110100;
            done = 6'($urandom);
            #1;
            vecs++;
            if (start !== 6'b0 || busy !== 1'b0 || cmd_out !== NOP) begin
                errs++;
                $display("FAIL init_gate c%0d: start=%b busy=%b cmd=%h",
                         c, start, busy, cmd_out);
            end
        end
        @(negedge clk);
        req = 6'b0;
        run_grant(6'b000001, 1, 0, 24'h654321);
    endtask

    task automatic test_priority();
        run_grant(6'b110100, 1, 0, 24'h654321);
        run_grant(6'b110000, 2, 1, 24'h654321);
        run_grant(6'b100000, 1, 2, 24'h654321);
        for (int i = 0; i < 3; i++) begin
            run_grant(6'b110000, $urandom_range(1, 3),
                      $urandom_range(0, 3), 24'($urandom));
        end
    endtask

    task automatic test_self_refresh();
        run_grant(6'b001000, 1, 0, 24'h654321);
        run_grant(6'b010110, 2, 0, 24'h654321);
        run_grant(6'b010100, 1, 1, 24'h654321);
        run_grant(6'b010000, 1, 0, 24'h654321);
    endtask

    task automatic test_random_mux();
        logic [5:0] r;
        for (int i = 0; i < 20; i++) begin
            r = 6'($urandom);
            if (pick(r) < 0) r[m_sr ? 1 : 4] = 1'b1;
            run_grant(r, $urandom_range(1, 3), $urandom_range(0, 3),
                      24'($urandom));
        end
    endtask

    task automatic test_done_at_limit();
        if (m_sr) run_grant(6'b000010, 1, 0, 24'h654321);
        run_grant(6'b010000, TO, 0, 24'h654321);
        run_grant(6'b100000, TO - 1, 0, 24'h654321);
    endtask

    task automatic test_timeout();
        if (m_sr) run_grant(6'b000010, 1, 0, 24'h654321);
        run_grant(6'b100000, 1, 0, 24'h654321);
        cmd_in = 24'h654321;
        @(negedge clk);
        req  = 6'b110000;
        done = 6'b0;
        for (int c = 1; c <= TO + 1; c++) begin
            @(negedge clk);
            req  = (c == TO + 1) ? 6'b100000 : 6'b110000;
            done = 6'($urandom) & 6'b101111;
            #1;
            vecs++;
            if (start !== ((c <= TO) ? 6'b010000 : 6'b0)) begin
                errs++;
                $display("FAIL to_start c%0d: got %b", c, start);
            end
            vecs++;
            if (ack !== 6'b0 || busy !== (c <= TO)) begin
                errs++;
                $display("FAIL to_ack_busy c%0d: ack=%b busy=%b", c, ack, busy);
            end
        end
        m_to = 1'b1;
        vecs++;
        if (timeout_err !== 1'b1) begin
            errs++;
            $display("FAIL to_err: got %b want 1", timeout_err);
        end
        @(negedge clk);
        done = 6'b100000;
        #1;
        vecs++;
        if (start !== 6'b100000 || cmd_out !== 4'h6) begin
            errs++;
            $display("FAIL to_next: start=%b cmd=%h want 100000/6",
                     start, cmd_out);
        end
        @(negedge clk);
        done = 6'b0;
        #1;
        vecs++;
        if (ack !== 6'b100000) begin
            errs++;
            $display("FAIL to_next_ack: got %b want 100000", ack);
        end
        req = 6'b0;
        m_lastwr = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        run_grant(6'b001000, 1, 0, 24'h654321);
        @(negedge clk);
        req  = 6'b000010;
        done = 6'b0;
        @(negedge clk);
        #1;
        vecs++;
        if (start !== 6'b000010) begin
            errs++;
            $display("FAIL rstmid_pre: start=%b want 000010", start);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        vecs++;
        if (start !== 6'b0 || busy !== 1'b0 || ack !== 6'b0) begin
            errs++;
            $display("FAIL rstmid_hs: start=%b busy=%b ack=%b want 0",
                     start, busy, ack);
        end
        vecs++;
        if ({init_done, self_ref, timeout_err} !== 3'b000) begin
            errs++;
            $display("FAIL rstmid_modes: got %b want 000",
                     {init_done, self_ref, timeout_err});
        end
        rst = 1'b0;
        req = 6'b0;
        model_reset();
        run_grant(6'b000001, 2, 1, 24'($urandom));
        run_grant(6'b110000, 1, 0, 24'($urandom));
        run_grant(6'b110000, 1, 0, 24'($urandom));
    endtask

    initial begin
        vecs   = 0;
        errs   = 0;
        rst    = 1'b1;
        req    = 6'b0;
        done   = 6'b0;
        cmd_in = 24'h654321;
        model_reset();
        test_reset();
        test_init_gating();
        test_priority();
        test_self_refresh();
        test_random_mux();
        test_done_at_limit();
        test_timeout();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
